coin_credit_acceptor: RTL and testbench

Upstream credit stage for the vending machine core: it accepts coin events, accumulates credit with saturation checking, and hands a committed credit value to the vending machine's `amount` input through a valid/ready handshake. It also returns credit as a refund on cancel or inactivity timeout. The vending machine only ever sees a stable, committed `amount`; it never sees a partially inserted sum.

---
 rtl/coin_credit_acceptor.sv | 193 +++++++++++++++++++
 tb/tb_coin_credit_acceptor.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_credit_acceptor.sv
`default_nettype none
// ============================================================================
//  Module      : coin_credit_acceptor
//  Description : Upstream credit stage for the vending machine core. It
//                accumulates coin credit with a saturation check, offers a
//                committed amount over a valid/ready handshake, and refunds
//                credit on cancel or, optionally, after an inactivity timeout.
//  Options     : COIN_TIMEOUT_EN - build the COLLECT inactivity timer that
//                auto-refunds after TIMEOUT_CYCLES idle cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module coin_credit_acceptor #(
  parameter int CREDIT_W       = 7,
  parameter int MAX_CREDIT     = 127,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TMR_W          = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic                done,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] amount,
  output logic                amount_valid,
  input  logic                amount_ready,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] refund,
  output logic                refund_valid,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_OFFER   = 2'd2,
    S_REFUND  = 2'd3
  } state_t;

  // Saturation limit held one bit wider than credit so the sum never wraps.
  localparam logic [CREDIT_W:0] c_max = (CREDIT_W+1)'(MAX_CREDIT);

  state_t              r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] r_amount;
  logic                r_amount_valid;
  logic                r_coin_reject;
  logic [CREDIT_W-1:0] r_refund;
  logic                r_refund_valid;
  logic                r_busy;

  logic [CREDIT_W:0]   w_coin_val;
  logic [CREDIT_W:0]   w_sum;
  logic                w_fits;
  logic                w_coin_acc;
  logic [CREDIT_W-1:0] w_post_credit;
  logic                w_timeout;

  // Decode the coin denomination into its credit value.
  always_comb begin
    w_coin_val = '0;
    case (coin_type)
      2'b00:   w_coin_val = (CREDIT_W+1)'(1);
      2'b01:   w_coin_val = (CREDIT_W+1)'(2);
      2'b10:   w_coin_val = (CREDIT_W+1)'(5);
      default: w_coin_val = (CREDIT_W+1)'(10);
    endcase
  end

  assign w_sum         = {1'b0, r_credit} + w_coin_val;
  assign w_fits        = (w_sum <= c_max);
  assign w_coin_acc    = coin_valid && w_fits;
  // Credit as it stands after this cycle's coin, used when done commits it.
  assign w_post_credit = w_coin_acc ? w_sum[CREDIT_W-1:0] : r_credit;

`ifdef COIN_TIMEOUT_EN
  localparam logic [TMR_W-1:0] c_timeout = TMR_W'(TIMEOUT_CYCLES);

  logic [TMR_W-1:0] r_tmr;
  logic [TMR_W-1:0] w_tmr_inc;

  assign w_tmr_inc = r_tmr + TMR_W'(1);
  // Timeout fires on the edge where the idle count reaches TIMEOUT_CYCLES.
  assign w_timeout = (r_state == S_COLLECT) && (w_tmr_inc == c_timeout);

  // Idle counter: runs only in COLLECT, restarts on entry and on each accepted coin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmr <= '0;
    end else if ((r_state != S_COLLECT) || w_timeout || w_coin_acc) begin
      r_tmr <= '0;
    end else begin
      r_tmr <= w_tmr_inc;
    end
  end
`else
  logic w_unused_cfg;

  assign w_timeout    = 1'b0;
  assign w_unused_cfg = (TIMEOUT_CYCLES != 0) ^ (TMR_W != 0);
`endif

  // Main controller: state, credit and every registered output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_credit       <= '0;
      r_amount       <= '0;
      r_amount_valid <= 1'b0;
      r_coin_reject  <= 1'b0;
      r_refund       <= '0;
      r_refund_valid <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_coin_reject  <= 1'b0;
      r_refund_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // done and cancel carry no meaning without credit.
          if (coin_valid) begin
            if (w_fits) begin
              r_credit <= w_sum[CREDIT_W-1:0];
              r_state  <= S_COLLECT;
              r_busy   <= 1'b1;
            end else begin
              r_coin_reject <= 1'b1;
            end
          end
        end
        S_COLLECT: begin
          if (w_timeout) begin
            // Strobes on the timeout cycle are dropped, including coins.
            r_refund       <= r_credit;
            r_refund_valid <= 1'b1;
            r_state        <= S_REFUND;
          end else if (cancel) begin
            // Cancel wins over done; a coin on the same cycle goes back.
            r_refund       <= r_credit;
            r_refund_valid <= 1'b1;
            r_coin_reject  <= coin_valid;
            r_state        <= S_REFUND;
          end else begin
            if (coin_valid) begin
              if (w_fits) begin
                r_credit <= w_sum[CREDIT_W-1:0];
              end else begin
                r_coin_reject <= 1'b1;
              end
            end
            if (done) begin
              r_amount       <= w_post_credit;
              r_amount_valid <= 1'b1;
              r_state        <= S_OFFER;
            end
          end
        end
        S_OFFER: begin
          // Credit is committed: coins bounce and cancel is ignored.
          r_coin_reject <= coin_valid;
          if (amount_ready) begin
            r_credit       <= '0;
            r_amount_valid <= 1'b0;
            r_state        <= S_IDLE;
            r_busy         <= 1'b0;
          end
        end
        S_REFUND: begin
          r_credit <= '0;
          r_refund <= '0;
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
        end
        default: begin
          r_credit       <= '0;
          r_amount_valid <= 1'b0;
          r_state        <= S_IDLE;
          r_busy         <= 1'b0;
        end
      endcase
    end
  end

  assign amount       = r_amount;
  assign amount_valid = r_amount_valid;
  assign coin_reject  = r_coin_reject;
  assign refund       = r_refund;
  assign refund_valid = r_refund_valid;
  assign credit       = r_credit;
  assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_coin_credit_acceptor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_coin_credit_acceptor
//  Description : Directed self-checking bench for coin_credit_acceptor.
//                Timeout scenario is built when COIN_TIMEOUT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_coin_credit_acceptor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_type = 2'b00;
  logic       done = 1'b0;
  logic       cancel = 1'b0;
  logic [6:0] amount;
  logic       amount_valid;
  logic       amount_ready = 1'b0;
  logic       coin_reject;
  logic [6:0] refund;
  logic       refund_valid;
  logic [6:0] credit;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  coin_credit_acceptor #(
    .CREDIT_W(7), .MAX_CREDIT(127), .TIMEOUT_CYCLES(20), .TMR_W(10)
  ) dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_type(coin_type),
    .done(done), .cancel(cancel), .amount(amount), .amount_valid(amount_valid),
    .amount_ready(amount_ready), .coin_reject(coin_reject), .refund(refund),
    .refund_valid(refund_valid), .credit(credit), .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a one-cycle coin strobe.
  task automatic put_coin(input logic [1:0] t);
    coin_valid = 1'b1;
    coin_type  = t;
    tick();
    coin_valid = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_checks++;
    if ({amount, amount_valid, coin_reject, refund, refund_valid, credit, busy} !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h exp 0", {amount, amount_valid, coin_reject, refund, refund_valid, credit, busy});
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle busy got %b exp 0", busy); end
  endtask

  task automatic test_collect_offer();
    put_coin(2'b11);
    n_checks++;
    if (credit !== 7'd10) begin n_fail++; $display("FAIL credit_10 got %0d exp 10", credit); end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_collect got %b exp 1", busy); end
    put_coin(2'b10);
    n_checks++;
    if (credit !== 7'd15) begin n_fail++; $display("FAIL credit_15 got %0d exp 15", credit); end
    put_coin(2'b01);
    n_checks++;
    if (credit !== 7'd17) begin n_fail++; $display("FAIL credit_17 got %0d exp 17", credit); end
    done = 1'b1;
    tick();
    done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (amount_valid !== 1'b1 || amount !== 7'd17) begin
        n_fail++;
        $display("FAIL offer_hold[%0d] valid %b amount %0d exp 1/17", i, amount_valid, amount);
      end
      tick();
    end
    amount_ready = 1'b1;
    tick();
    amount_ready = 1'b0;
    n_checks++;
    if (amount_valid !== 1'b0 || credit !== 7'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL handshake_done valid %b credit %0d busy %b exp 0/0/0", amount_valid, credit, busy);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 12; i++) put_coin(2'b11);
    n_checks++;
    if (credit !== 7'd120) begin n_fail++; $display("FAIL sat_120 got %0d exp 120", credit); end
    put_coin(2'b11);
    n_checks++;
    if (coin_reject !== 1'b1 || credit !== 7'd120) begin
      n_fail++;
      $display("FAIL sat_reject reject %b credit %0d exp 1/120", coin_reject, credit);
    end
    tick();
    n_checks++;
    if (coin_reject !== 1'b0) begin n_fail++; $display("FAIL sat_reject_pulse got %b exp 0", coin_reject); end
    put_coin(2'b10);
    n_checks++;
    if (credit !== 7'd125 || coin_reject !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_125 credit %0d reject %b exp 125/0", credit, coin_reject);
    end
    put_coin(2'b01);
    n_checks++;
    if (credit !== 7'd127 || coin_reject !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_127 credit %0d reject %b exp 127/0", credit, coin_reject);
    end
    put_coin(2'b00);
    n_checks++;
    if (credit !== 7'd127 || coin_reject !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_full credit %0d reject %b exp 127/1", credit, coin_reject);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    n_checks++;
    if (amount !== 7'd127) begin n_fail++; $display("FAIL sat_amount got %0d exp 127", amount); end
    amount_ready = 1'b1;
    tick();
    amount_ready = 1'b0;
  endtask

  task automatic test_cancel_done();
    put_coin(2'b10);
    put_coin(2'b01);
    put_coin(2'b00);
    n_checks++;
    if (credit !== 7'd8) begin n_fail++; $display("FAIL cancel_credit got %0d exp 8", credit); end
    cancel = 1'b1;
    done   = 1'b1;
    tick();
    cancel = 1'b0;
    done   = 1'b0;
    n_checks++;
    if (refund_valid !== 1'b1 || refund !== 7'd8 || amount_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL cancel_refund rv %b refund %0d av %b busy %b exp 1/8/0/1", refund_valid, refund, amount_valid, busy);
    end
    tick();
    n_checks++;
    if (refund_valid !== 1'b0 || busy !== 1'b0 || credit !== 7'd0 || amount_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL cancel_idle rv %b busy %b credit %0d av %b exp 0/0/0/0", refund_valid, busy, credit, amount_valid);
    end
  endtask

  task automatic test_cancel_coin();
    put_coin(2'b10);
    coin_valid = 1'b1;
    coin_type  = 2'b11;
    cancel     = 1'b1;
    tick();
    coin_valid = 1'b0;
    cancel     = 1'b0;
    n_checks++;
    if (coin_reject !== 1'b1 || refund_valid !== 1'b1 || refund !== 7'd5) begin
      n_fail++;
      $display("FAIL cancel_coin reject %b rv %b refund %0d exp 1/1/5", coin_reject, refund_valid, refund);
    end
    tick();
  endtask

  task automatic test_coin_with_done();
    // Ready while nothing is offered must not disturb collection.
    amount_ready = 1'b1;
    put_coin(2'b10);
    tick();
    amount_ready = 1'b0;
    n_checks++;
    if (credit !== 7'd5 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL early_ready credit %0d busy %b exp 5/1", credit, busy);
    end
    coin_valid = 1'b1;
    coin_type  = 2'b01;
    done       = 1'b1;
    tick();
    coin_valid = 1'b0;
    done       = 1'b0;
    n_checks++;
    if (amount_valid !== 1'b1 || amount !== 7'd7) begin
      n_fail++;
      $display("FAIL coin_done valid %b amount %0d exp 1/7", amount_valid, amount);
    end
    amount_ready = 1'b1;
    tick();
    amount_ready = 1'b0;
  endtask

  task automatic test_offer_coin_cancel();
    put_coin(2'b10);
    put_coin(2'b00);
    done = 1'b1;
    tick();
    done = 1'b0;
    n_checks++;
    if (amount_valid !== 1'b1 || amount !== 7'd6) begin
      n_fail++;
      $display("FAIL offer6 valid %b amount %0d exp 1/6", amount_valid, amount);
    end
    coin_valid = 1'b1;
    coin_type  = 2'b00;
    cancel     = 1'b1;
    tick();
    coin_valid = 1'b0;
    cancel     = 1'b0;
    n_checks++;
    if (coin_reject !== 1'b1 || amount_valid !== 1'b1 || amount !== 7'd6 || refund_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL offer_coin_cancel reject %b av %b amount %0d rv %b exp 1/1/6/0", coin_reject, amount_valid, amount, refund_valid);
    end
    tick();
    n_checks++;
    if (amount_valid !== 1'b1 || amount !== 7'd6 || coin_reject !== 1'b0) begin
      n_fail++;
      $display("FAIL offer_stable av %b amount %0d reject %b exp 1/6/0", amount_valid, amount, coin_reject);
    end
    amount_ready = 1'b1;
    tick();
    amount_ready = 1'b0;
    n_checks++;
    if (amount_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL offer_release av %b busy %b exp 0/0", amount_valid, busy);
    end
  endtask

`ifdef COIN_TIMEOUT_EN
  task automatic test_timeout();
    put_coin(2'b10);
    for (int i = 0; i < 19; i++) tick();
    n_checks++;
    if (refund_valid !== 1'b0) begin n_fail++; $display("FAIL to_early got %b exp 0", refund_valid); end
    tick();
    n_checks++;
    if (refund_valid !== 1'b1 || refund !== 7'd5) begin
      n_fail++;
      $display("FAIL to_refund rv %b refund %0d exp 1/5", refund_valid, refund);
    end
    tick();
    put_coin(2'b10);
    for (int i = 0; i < 14; i++) tick();
    put_coin(2'b00);
    for (int i = 0; i < 19; i++) tick();
    n_checks++;
    if (refund_valid !== 1'b0 || credit !== 7'd6) begin
      n_fail++;
      $display("FAIL to_restart rv %b credit %0d exp 0/6", refund_valid, credit);
    end
    tick();
    n_checks++;
    if (refund_valid !== 1'b1 || refund !== 7'd6) begin
      n_fail++;
      $display("FAIL to_refund2 rv %b refund %0d exp 1/6", refund_valid, refund);
    end
    tick();
  endtask
`else
  task automatic test_no_timeout();
    put_coin(2'b10);
    for (int i = 0; i < 40; i++) tick();
    n_checks++;
    if (credit !== 7'd5 || busy !== 1'b1 || refund_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL no_timeout credit %0d busy %b rv %b exp 5/1/0", credit, busy, refund_valid);
    end
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    tick();
  endtask
`endif

  task automatic test_reset_mid();
    put_coin(2'b10);
    put_coin(2'b01);
    put_coin(2'b01);
    n_checks++;
    if (credit !== 7'd9) begin n_fail++; $display("FAIL mid_credit got %0d exp 9", credit); end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({amount, amount_valid, coin_reject, refund, refund_valid, credit, busy} !== 24'd0) begin
      n_fail++;
      $display("FAIL mid_reset_async got %h exp 0", {amount, amount_valid, coin_reject, refund, refund_valid, credit, busy});
    end
    tick();
    tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if (refund_valid !== 1'b0 || credit !== 7'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_after rv %b credit %0d busy %b exp 0/0/0", refund_valid, credit, busy);
    end
  endtask

  initial begin
    test_reset();
    test_collect_offer();
    test_saturation();
    test_cancel_done();
    test_cancel_coin();
    test_coin_with_done();
    test_offer_coin_cancel();
`ifdef COIN_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net in case the sequence above stalls.
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
`default_nettype wire
